// File: rtl/life_pkg.sv
// Shared types and geometry helpers for the Game-of-Life grid engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STEP,
        SWAP
    } state_t;

    localparam int N_DEF = 40;
    localparam int M_DEF = 30;
    localparam int CELLS = N_DEF * M_DEF;

    function automatic int cell_count(int n, int m);
        return n * m;
    endfunction

    function automatic int idx_width(int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

    // Torus neighbour index; wrap by compare/select so no divider is built.
    function automatic int wrap_idx(int row, int col, int dr, int dc,
                                    int n, int m);
        int r;
        int c;
        r = row + dr;
        c = col + dc;
        if (r < 0)
            r = m - 1;
        else if (r >= m)
            r = 0;
        if (c < 0)
            c = n - 1;
        else if (c >= n)
            c = 0;
        return r * n + c;
    endfunction

endpackage

// File: rtl/life_rule.sv
// B3/S23 cell update: eight neighbour bits plus the cell's own state.
module life_rule (
    input  logic [7:0] nbr,
    input  logic       alive,
    output logic       next_alive
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++)
            count = count + {3'b000, nbr[i]};
    end

    assign next_alive = (count == 4'd3) || (alive && count == 4'd2);

endmodule

// File: rtl/life_grid_engine.sv
// Ping-pong Game-of-Life grid: display read port, cell edits, step/clear FSM.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int P_PARAM_N = N_DEF,
    parameter int P_PARAM_M = M_DEF,
    parameter int GEN_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               clear,
    input  logic               edit_toggle,
    input  logic [2*WIDTH-1:0] edit_pos,
    input  logic [2*WIDTH-1:0] rd_pos,
    output logic               rd_live,
    output logic               busy,
    output logic               done,
    output logic [GEN_W-1:0]   generation
);

    localparam int NC = cell_count(P_PARAM_N, P_PARAM_M);
    localparam int IW = idx_width(NC);
    localparam int RW = idx_width(P_PARAM_M);
    localparam int CW = idx_width(P_PARAM_N);

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  idx;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic           bank_sel;
    logic [NC-1:0]  bank [2];
    logic [NC-1:0]  cur;
    logic           last;
    logic           restart;
    logic           adv;
    logic           rd_ok;
    logic           ed_ok;
    logic [7:0]     nbr;
    logic           next_alive;

    function automatic logic [IW-1:0] nidx(logic [RW-1:0] r,
                                           logic [CW-1:0] c,
                                           int dr, int dc);
        return IW'(wrap_idx(int'(r), int'(c), dr, dc,
                            P_PARAM_N, P_PARAM_M));
    endfunction

    assign cur   = bank[bank_sel];
    assign last  = (idx == IW'(NC - 1));
    assign rd_ok = (rd_pos < (2*WIDTH)'(NC));
    assign ed_ok = (edit_pos < (2*WIDTH)'(NC));

    always_comb begin
        nbr[0] = cur[nidx(row, col, -1, -1)];
        nbr[1] = cur[nidx(row, col, -1,  0)];
        nbr[2] = cur[nidx(row, col, -1,  1)];
        nbr[3] = cur[nidx(row, col,  0, -1)];
        nbr[4] = cur[nidx(row, col,  0,  1)];
        nbr[5] = cur[nidx(row, col,  1, -1)];
        nbr[6] = cur[nidx(row, col,  1,  0)];
        nbr[7] = cur[nidx(row, col,  1,  1)];
    end

    life_rule u_rule (
        .nbr        (nbr),
        .alive      (cur[idx]),
        .next_alive (next_alive)
    );

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        adv      = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    state_nx = CLEAR;
                    restart  = 1'b1;
                end else if (step) begin
                    state_nx = STEP;
                    restart  = 1'b1;
                end
            end
            CLEAR: begin
                if (clear) begin
                    restart = 1'b1;
                end else if (last) begin
                    state_nx = IDLE;
                    restart  = 1'b1;
                end else begin
                    adv = 1'b1;
                end
            end
            STEP: begin
                if (clear) begin
                    state_nx = CLEAR;
                    restart  = 1'b1;
                end else if (last) begin
                    state_nx = SWAP;
                    restart  = 1'b1;
                end else begin
                    adv = 1'b1;
                end
            end
            SWAP: begin
                state_nx = clear ? CLEAR : IDLE;
                restart  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            bank_sel   <= 1'b0;
            bank[0]    <= '0;
            bank[1]    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_live    <= 1'b0;
            generation <= '0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx == CLEAR) || (state_nx == STEP);
            done    <= 1'b0;
            rd_live <= rd_ok ? cur[rd_pos[IW-1:0]] : 1'b0;

            if (restart) begin
                idx <= '0;
                row <= '0;
                col <= '0;
            end else if (adv) begin
                idx <= idx + IW'(1);
                if (col == CW'(P_PARAM_N - 1)) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            unique case (state)
                IDLE: begin
                    if (!clear && edit_toggle && ed_ok)
                        bank[bank_sel][edit_pos[IW-1:0]] <=
                            ~cur[edit_pos[IW-1:0]];
                end
                CLEAR: begin
                    bank[0][idx] <= 1'b0;
                    bank[1][idx] <= 1'b0;
                    if (!clear && last) begin
                        done       <= 1'b1;
                        generation <= '0;
                    end
                end
                STEP: begin
                    if (!clear)
                        bank[~bank_sel][idx] <= next_alive;
                end
                SWAP: begin
                    bank_sel   <= ~bank_sel;
                    generation <= generation + GEN_W'(1);
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
